// File: rtl/inst_fetcher.sv
// ----------------------------------------------------------------------------
// inst_fetcher
//
// Front-end instruction fetch unit. It keeps a program counter and issues one
// fetch at a time to the instruction cache. Returned instructions go into a
// small circular queue of {address, instruction} pairs. The queue head is
// presented to the decoder.
//
// A flush from the reorder buffer (rob_clear) or a decoder redirect
// (dec_redirect) does three things: it empties the queue, it reloads the PC,
// and it makes sure the one fetch that may still be in flight is thrown away
// when it returns.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   rdy_in                  global ready; low freezes every piece of state
//   ic_req_valid/addr       fetch request to the instruction cache
//   ic_resp_valid/inst      one-cycle response pulse from the cache
//   dec_valid/inst_addr/inst  queue head presented to the decoder
//   dec_stall               decoder cannot take the head this cycle
//   dec_redirect/set_addr   decoder-resolved redirect and its target
//   rob_clear/set_addr      misprediction flush and the correct-path target
// ----------------------------------------------------------------------------
module inst_fetcher #(
   parameter int          IQ_DEPTH_BIT = 2,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_inst,
   output logic        dec_valid,
   output logic [31:0] dec_inst_addr,
   output logic [31:0] dec_inst,
   input  logic        dec_stall,
   input  logic        dec_redirect,
   input  logic [31:0] dec_set_addr,
   input  logic        rob_clear,
   input  logic [31:0] rob_set_addr
);

   localparam int DEPTH = 1 << IQ_DEPTH_BIT;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   localparam logic [IQ_DEPTH_BIT-1:0] PTR_ONE  = IQ_DEPTH_BIT'(1);
   localparam logic [IQ_DEPTH_BIT:0]   CNT_ONE  = (IQ_DEPTH_BIT+1)'(1);
   localparam logic [IQ_DEPTH_BIT:0]   CNT_ZERO = (IQ_DEPTH_BIT+1)'(0);
   localparam logic [IQ_DEPTH_BIT:0]   CNT_FULL = (IQ_DEPTH_BIT+1)'(DEPTH);

   // Architectural state
   logic [31:0]             pc;
   logic [31:0]             req_addr;
   logic [1:0]              state;
   logic [IQ_DEPTH_BIT-1:0] head;
   logic [IQ_DEPTH_BIT-1:0] tail;
   logic [IQ_DEPTH_BIT:0]   count;
   logic [31:0]             addr_mem [DEPTH];
   logic [31:0]             inst_mem [DEPTH];

   // Next-state values
   logic [31:0]             pc_nxt;
   logic [31:0]             req_addr_nxt;
   logic [1:0]              state_nxt;
   logic [IQ_DEPTH_BIT-1:0] head_nxt;
   logic [IQ_DEPTH_BIT-1:0] tail_nxt;
   logic [IQ_DEPTH_BIT:0]   count_nxt;

   // Per-cycle control decisions
   logic        flush;
   logic [31:0] flush_addr;
   logic        q_full;
   logic        req_fire;
   logic        push;
   logic        pop;

   // Qualify every control event with rdy_in so a low rdy_in freezes all state.
   always_comb begin
      flush      = rdy_in & (rob_clear | dec_redirect);
      // rob_clear outranks a decoder redirect raised in the same cycle.
      flush_addr = rob_clear ? rob_set_addr : dec_set_addr;
      q_full     = (count == CNT_FULL);
      // Nothing can be in flight in IDLE, so the queue occupancy alone
      // decides whether a response would find room. The request is also
      // gated with rst_in so that it stays low while reset is held.
      req_fire   = rst_in & rdy_in & (state == ST_IDLE) & ~q_full & ~flush;
      // A response that arrives together with a flush belongs to the wrong
      // path, so it is never pushed.
      push       = rdy_in & (state == ST_WAIT) & ic_resp_valid & ~flush;
      pop        = rdy_in & (count != CNT_ZERO) & ~dec_stall & ~dec_redirect & ~rob_clear;
   end

   // Drive the cache request and the decoder view of the queue head.
   always_comb begin
      ic_req_valid  = req_fire;
      ic_req_addr   = pc;
      dec_valid     = (count != CNT_ZERO);
      dec_inst_addr = addr_mem[head];
      dec_inst      = inst_mem[head];
   end

   // Compute the next fetch-FSM state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_fire) begin
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!rdy_in) begin
               state_nxt = ST_WAIT;
            end else if (ic_resp_valid) begin
               // This is taken both for a normal response and for one that
               // is dropped because a flush arrives in the same cycle.
               state_nxt = ST_IDLE;
            end else if (flush) begin
               // The request is still outstanding, so its response has to
               // be absorbed before a new fetch can start.
               state_nxt = ST_DISCARD;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_DISCARD: begin
            if (rdy_in && ic_resp_valid) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DISCARD;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Compute the next PC and the latched request address.
   always_comb begin
      pc_nxt       = pc;
      req_addr_nxt = req_addr;
      if (flush) begin
         pc_nxt = flush_addr;
      end else if (push) begin
         pc_nxt = req_addr + 32'd4;
      end else begin
         pc_nxt = pc;
      end
      if (req_fire) begin
         req_addr_nxt = pc;
      end else begin
         req_addr_nxt = req_addr;
      end
   end

   // Compute the next queue pointers and occupancy.
   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      if (flush) begin
         // A flush never coincides with a push, so tail stays put and the
         // queue is emptied by moving head onto it.
         head_nxt  = tail;
         tail_nxt  = tail;
         count_nxt = CNT_ZERO;
      end else begin
         if (push) begin
            tail_nxt = tail + PTR_ONE;
         end else begin
            tail_nxt = tail;
         end
         if (pop) begin
            head_nxt = head + PTR_ONE;
         end else begin
            head_nxt = head;
         end
         case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
         endcase
      end
   end

   // Register the PC, the FSM state and the queue control.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         state    <= ST_IDLE;
         head     <= '0;
         tail     <= '0;
         count    <= CNT_ZERO;
      end else begin
         pc       <= pc_nxt;
         req_addr <= req_addr_nxt;
         state    <= state_nxt;
         head     <= head_nxt;
         tail     <= tail_nxt;
         count    <= count_nxt;
      end
   end

   // Write returned instructions into the queue storage at the tail.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= 32'h0000_0000;
            inst_mem[i] <= 32'h0000_0000;
         end
      end else if (push) begin
         addr_mem[tail] <= req_addr;
         inst_mem[tail] <= ic_resp_inst;
      end
   end

endmodule
